// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard / forwarding unit.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned FSEL_W_DEF = 2;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

  localparam logic [FSEL_W_DEF-1:0] FSEL_RF    = 2'd0;
  localparam logic [FSEL_W_DEF-1:0] FSEL_EXMEM = 2'd1;
  localparam logic [FSEL_W_DEF-1:0] FSEL_MEMWB = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Single-operand forwarding priority encoder: nearest writing stage wins, r0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NSTG   = 2,
  parameter int unsigned FSEL_W = 2
) (
  input  logic [REG_AW-1:0]      i_src,
  input  logic [NSTG-1:0]        i_regwrite,
  input  logic [NSTG*REG_AW-1:0] i_dest,
  output logic [FSEL_W-1:0]      o_sel
);

  logic [NSTG-1:0] w_hit;

  for (genvar k = 0; k < NSTG; k++) begin : g_hit
    logic [REG_AW-1:0] w_dest;
    assign w_dest   = i_dest[k*REG_AW +: REG_AW];
    assign w_hit[k] = i_regwrite[k] && (w_dest != '0) && (w_dest == i_src);
  end

  // Scan from the farthest stage down so the nearest hit overwrites.
  always_comb begin
    o_sel = FSEL_W'(FSEL_RF);
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_sel = FSEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use / MDU hazard stall generation and a stall performance counter.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned NSTG    = 2,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned PERF_W  = 16,
  localparam int unsigned FSEL_W = $clog2(NSTG + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC*REG_AW-1:0]   i_ex_src,
  input  logic [NSTG-1:0]          i_stg_regwrite,
  input  logic [NSTG*REG_AW-1:0]   i_stg_dest,
  output logic [NSRC*FSEL_W-1:0]   o_fwd_sel,
  input  logic [NSRC*REG_AW-1:0]   i_id_src,
  input  logic [NSRC-1:0]          i_id_src_used,
  input  logic                     i_id_is_mdu,
  input  logic                     i_ex_memread,
  input  logic [REG_AW-1:0]        i_ex_dest,
  input  logic                     i_mdu_start,
  input  logic [REG_AW-1:0]        i_mdu_dest,
  output logic                     o_mdu_busy,
  output logic                     o_mdu_done,
  output logic                     o_stall,
  input  logic                     i_perf_clr,
  output logic [PERF_W-1:0]        o_stall_count
);

  localparam int unsigned CNT_W = (MDU_LAT < 2) ? 1 : $clog2(MDU_LAT);

  if (MDU_LAT < 2) begin : g_bad_lat
    $error("hazard_forward_unit: MDU_LAT must be >= 2");
  end

  mdu_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [REG_AW-1:0]  r_pend_dest;
  logic               r_mdu_done;
  logic [PERF_W-1:0]  r_stall_count;

  logic               w_busy;
  logic               w_ld_match;
  logic               w_pend_match;
  logic               w_load_use;
  logic               w_mdu_raw;
  logic               w_mdu_struct;
  logic               w_stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_select #(
      .REG_AW (REG_AW),
      .NSTG   (NSTG),
      .FSEL_W (FSEL_W)
    ) u_fwd_select (
      .i_src      (i_ex_src[i*REG_AW +: REG_AW]),
      .i_regwrite (i_stg_regwrite),
      .i_dest     (i_stg_dest),
      .o_sel      (o_fwd_sel[i*FSEL_W +: FSEL_W])
    );
  end

  // Match used ID sources against the EX load destination and the pending MDU destination.
  always_comb begin
    w_ld_match   = 1'b0;
    w_pend_match = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (i_id_src_used[i] && (i_id_src[i*REG_AW +: REG_AW] == i_ex_dest)) begin
        w_ld_match = 1'b1;
      end
      if (i_id_src_used[i] && (i_id_src[i*REG_AW +: REG_AW] == r_pend_dest)) begin
        w_pend_match = 1'b1;
      end
    end
  end

  assign w_busy       = (r_state == BUSY);
  assign w_load_use   = i_ex_memread && (i_ex_dest != '0) && w_ld_match;
  assign w_mdu_raw    = w_busy && (r_pend_dest != '0) && w_pend_match;
  assign w_mdu_struct = i_id_is_mdu && w_busy && !r_mdu_done;
  assign w_stall      = w_load_use || w_mdu_raw || w_mdu_struct;

  // MDU scoreboard; done is registered one cycle ahead as "next cnt reaches 0 while busy".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pend_dest <= '0;
      r_mdu_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mdu_done <= 1'b0;
          if (i_mdu_start) begin
            r_pend_dest <= i_mdu_dest;
            r_cnt       <= CNT_W'(MDU_LAT - 1);
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          r_mdu_done <= (r_cnt == CNT_W'(1));
          if (r_cnt == '0) begin
            if (i_mdu_start) begin
              r_pend_dest <= i_mdu_dest;
              r_cnt       <= CNT_W'(MDU_LAT - 1);
            end else begin
              r_pend_dest <= '0;
              r_state     <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_mdu_done <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (i_perf_clr) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + PERF_W'(1);
    end
  end

  assign o_mdu_busy    = w_busy;
  assign o_mdu_done    = r_mdu_done;
  assign o_stall       = w_stall;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding/load-use table plus MDU and counter sequences.
module tb_hazard_forward_unit;
  import hazard_pkg::*;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NSRC   = 3;
  localparam int unsigned NSTG   = 2;
  localparam int unsigned PERF_W = 16;
  localparam int unsigned FSEL_W = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NSRC*REG_AW-1:0] ex_src;
  logic [NSTG-1:0]        stg_regwrite;
  logic [NSTG*REG_AW-1:0] stg_dest;
  logic [NSRC*FSEL_W-1:0] fwd_sel;
  logic [NSRC*REG_AW-1:0] id_src;
  logic [NSRC-1:0]        id_src_used;
  logic                   id_is_mdu;
  logic                   ex_memread;
  reg_addr_t              ex_dest;
  logic                   mdu_start;
  reg_addr_t              mdu_dest;
  logic                   mdu_busy;
  logic                   mdu_done;
  logic                   stall;
  logic                   perf_clr;
  logic [PERF_W-1:0]      stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_ex_src       (ex_src),
    .i_stg_regwrite (stg_regwrite),
    .i_stg_dest     (stg_dest),
    .o_fwd_sel      (fwd_sel),
    .i_id_src       (id_src),
    .i_id_src_used  (id_src_used),
    .i_id_is_mdu    (id_is_mdu),
    .i_ex_memread   (ex_memread),
    .i_ex_dest      (ex_dest),
    .i_mdu_start    (mdu_start),
    .i_mdu_dest     (mdu_dest),
    .o_mdu_busy     (mdu_busy),
    .o_mdu_done     (mdu_done),
    .o_stall        (stall),
    .i_perf_clr     (perf_clr),
    .o_stall_count  (stall_count)
  );

  typedef struct {
    logic [NSRC*REG_AW-1:0] ex_src;
    logic [NSTG-1:0]        regw;
    logic [NSTG*REG_AW-1:0] stg_dest;
    logic [NSRC*REG_AW-1:0] id_src;
    logic [NSRC-1:0]        used;
    logic                   memread;
    logic [REG_AW-1:0]      ex_dest;
    logic [NSRC*FSEL_W-1:0] exp_fwd;
    logic                   exp_stall;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [NSRC*REG_AW-1:0] p3(input int a, input int b, input int c);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [NSTG*REG_AW-1:0] p2(input int a, input int b);
    return {5'(b), 5'(a)};
  endfunction

  function automatic logic [NSRC*FSEL_W-1:0] f3(input logic [1:0] a, input logic [1:0] b,
                                                input logic [1:0] c);
    return {c, b, a};
  endfunction

  function automatic vec_t mk(input logic [14:0] xs, input logic [1:0] rw, input logic [9:0] sd,
                              input logic [14:0] is, input logic [2:0] u, input logic mr,
                              input int ed, input logic [5:0] ef, input logic es);
    vec_t v;
    v.ex_src = xs; v.regw = rw; v.stg_dest = sd; v.id_src = is; v.used = u;
    v.memread = mr; v.ex_dest = 5'(ed); v.exp_fwd = ef; v.exp_stall = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting the MDU mid-operation is illegal stimulus; flag it if it ever appears.
  always @(negedge clk) begin
    if (rst_n && mdu_start && mdu_busy && !mdu_done) begin
      n_fail++;
      $display("FAIL illegal_mdu_start busy=%0b done=%0b", mdu_busy, mdu_done);
    end
  end

  initial begin
    rst_n = 1'b0; ex_src = '0; stg_regwrite = '0; stg_dest = '0; id_src = '0;
    id_src_used = '0; id_is_mdu = 1'b0; ex_memread = 1'b0; ex_dest = '0;
    mdu_start = 1'b0; mdu_dest = '0; perf_clr = 1'b0;

    vecs[0]  = mk(p3(5,0,0), 2'b11, p2(5,5), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_EXMEM,FSEL_RF,FSEL_RF), 0);
    vecs[1]  = mk(p3(5,0,0), 2'b10, p2(5,5), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_MEMWB,FSEL_RF,FSEL_RF), 0);
    vecs[2]  = mk(p3(0,0,0), 2'b11, p2(0,0), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_RF,FSEL_RF,FSEL_RF), 0);
    vecs[3]  = mk(p3(5,0,0), 2'b11, p2(0,0), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_RF,FSEL_RF,FSEL_RF), 0);
    vecs[4]  = mk(p3(9,7,3), 2'b11, p2(7,9), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_MEMWB,FSEL_EXMEM,FSEL_RF), 0);
    vecs[5]  = mk(p3(1,2,4), 2'b11, p2(4,4), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_RF,FSEL_RF,FSEL_EXMEM), 0);
    vecs[6]  = mk(p3(6,6,6), 2'b00, p2(6,6), p3(0,0,0), 3'b000, 0, 0, f3(FSEL_RF,FSEL_RF,FSEL_RF), 0);
    vecs[7]  = mk(p3(0,0,0), 2'b00, p2(0,0), p3(0,8,0), 3'b010, 1, 8, f3(FSEL_RF,FSEL_RF,FSEL_RF), 1);
    vecs[8]  = mk(p3(0,0,0), 2'b00, p2(0,0), p3(0,8,0), 3'b101, 1, 8, f3(FSEL_RF,FSEL_RF,FSEL_RF), 0);
    vecs[9]  = mk(p3(0,0,0), 2'b00, p2(0,0), p3(0,0,0), 3'b111, 1, 0, f3(FSEL_RF,FSEL_RF,FSEL_RF), 0);
    vecs[10] = mk(p3(0,0,0), 2'b00, p2(0,0), p3(0,8,0), 3'b010, 0, 8, f3(FSEL_RF,FSEL_RF,FSEL_RF), 0);
    vecs[11] = mk(p3(8,8,8), 2'b01, p2(8,3), p3(3,4,8), 3'b100, 1, 8, f3(FSEL_EXMEM,FSEL_EXMEM,FSEL_EXMEM), 1);

    // Reset state, and the load-use term stays live while in reset.
    #12;
    check("rst_busy", 32'(mdu_busy), 32'd0);
    check("rst_done", 32'(mdu_done), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    ex_memread = 1'b1; ex_dest = 5'd8; id_src = p3(0,8,0); id_src_used = 3'b010;
    #1;
    check("rst_load_use", 32'(stall), 32'd1);
    ex_memread = 1'b0; ex_dest = '0; id_src = '0; id_src_used = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      ex_src = vecs[i].ex_src; stg_regwrite = vecs[i].regw; stg_dest = vecs[i].stg_dest;
      id_src = vecs[i].id_src; id_src_used = vecs[i].used;
      ex_memread = vecs[i].memread; ex_dest = vecs[i].ex_dest;
      #1;
      check($sformatf("vec%0d_fwd", i), 32'(fwd_sel), 32'(vecs[i].exp_fwd));
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
    end
    ex_src = '0; stg_regwrite = '0; stg_dest = '0; id_src = '0; id_src_used = '0;
    ex_memread = 1'b0; ex_dest = '0;
    #1;
    check("count_pre_mdu", 32'(stall_count), 32'd0);

    // MDU RAW: dependent operand stalls for all four busy cycles.
    id_src = p3(10,0,0); id_src_used = 3'b001; mdu_start = 1'b1; mdu_dest = 5'd10;
    #1;
    check("raw_idle_stall", 32'(stall), 32'd0);
    tick();
    mdu_start = 1'b0; mdu_dest = '0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("raw_busy_c%0d", c), 32'(mdu_busy), 32'd1);
      check($sformatf("raw_done_c%0d", c), 32'(mdu_done), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("raw_stall_c%0d", c), 32'(stall), 32'd1);
      tick();
    end
    check("raw_after_busy", 32'(mdu_busy), 32'd0);
    check("raw_after_done", 32'(mdu_done), 32'd0);
    check("raw_after_stall", 32'(stall), 32'd0);
    check("raw_count", 32'(stall_count), 32'd4);
    id_src = '0; id_src_used = '0;

    // Back-to-back MDU with structural stall on a second MDU instruction.
    mdu_start = 1'b1; mdu_dest = 5'd11;
    tick();
    mdu_start = 1'b0; mdu_dest = '0; id_is_mdu = 1'b1;
    #1;
    check("b2b_struct_stall", 32'(stall), 32'd1);
    tick(); tick(); tick();
    check("b2b_done1", 32'(mdu_done), 32'd1);
    check("b2b_struct_on_done", 32'(stall), 32'd0);
    id_is_mdu = 1'b0; mdu_start = 1'b1; mdu_dest = 5'd12;
    tick();
    mdu_start = 1'b0; mdu_dest = '0;
    check("b2b_busy_cont", 32'(mdu_busy), 32'd1);
    check("b2b_done_clear", 32'(mdu_done), 32'd0);
    id_src = p3(11,0,0); id_src_used = 3'b001;
    #1;
    check("b2b_old_dest", 32'(stall), 32'd0);
    id_src = p3(0,12,0); id_src_used = 3'b010;
    #1;
    check("b2b_new_dest", 32'(stall), 32'd1);
    check("b2b_count", 32'(stall_count), 32'd7);
    id_src = '0; id_src_used = '0;
    tick(); tick(); tick();
    check("b2b_done2", 32'(mdu_done), 32'd1);
    tick();
    check("b2b_idle", 32'(mdu_busy), 32'd0);

    // Reset while BUSY at cnt = 2 aborts without a done pulse.
    id_src = p3(13,0,0); id_src_used = 3'b001; mdu_start = 1'b1; mdu_dest = 5'd13;
    tick();
    mdu_start = 1'b0; mdu_dest = '0;
    tick();
    check("mid_count_pre", 32'(stall_count), 32'd8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(mdu_busy), 32'd0);
    check("mid_rst_done", 32'(mdu_done), 32'd0);
    check("mid_rst_count", 32'(stall_count), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("mid_no_done_c%0d", c), 32'({mdu_busy, mdu_done}), 32'd0);
      tick();
    end
    id_src = '0; id_src_used = '0;

    // Saturation over 2^16 + 3 stalled cycles, then clear-vs-increment priority.
    ex_memread = 1'b1; ex_dest = 5'd8; id_src = p3(0,8,0); id_src_used = 3'b010;
    #1;
    check("sat_stall", 32'(stall), 32'd1);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(stall_count), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(stall_count), 32'hFFFF);
    repeat (4) tick();
    check("sat_hold", 32'(stall_count), 32'hFFFF);
    perf_clr = 1'b1;
    tick();
    check("clr_with_stall", 32'(stall_count), 32'd0);
    perf_clr = 1'b0;
    tick();
    check("inc_after_clr", 32'(stall_count), 32'd1);
    ex_memread = 1'b0; ex_dest = '0; id_src = '0; id_src_used = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline forwarding unit. Generalises forwarding to NSRC EX-stage operands and NSTG forwarding stages, with a fixed nearest-stage priority.
- Adds sequential hazard handling the older unit lacks: load-use stall detection, a scoreboard for one multi-cycle MDU (mult/div) with a latency counter, and a saturating stall performance counter.
- Sits beside the ID/EX register. Its outputs drive the EX operand muxes and the PC/IF-ID/ID-EX stall and bubble controls.

Parameters:
- REG_AW, 5, register address width.
- NSRC, 3, operands checked per instruction (rs, rt, store-data rd).
- NSTG, 2, forwarding stages after EX. Index 0 = EX/MEM, 1 = MEM/WB.
- MDU_LAT, 4, MDU cycles from start to result. Must be >= 2; elaborate-time error otherwise.
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_src  in  NSRC*REG_AW  EX-stage source register numbers.
- stg_regwrite  in  NSTG  per-stage write enable.
- stg_dest  in  NSTG*REG_AW  per-stage destination register.
- fwd_sel  out  NSRC*FSEL_W  per-operand select. 0 = register file, k+1 = stage k. FSEL_W = $clog2(NSTG+1).
- id_src  in  NSRC*REG_AW  ID-stage source registers.
- id_src_used  in  NSRC  marks which ID sources are real.
- id_is_mdu  in  1  ID instruction needs the MDU.
- ex_memread  in  1  EX instruction is a load.
- ex_dest  in  REG_AW  EX destination register.
- mdu_start  in  1  EX issues an MDU operation this cycle.
- mdu_dest  in  REG_AW  destination of the issued MDU operation.
- mdu_busy  out  1  scoreboard has a pending MDU result.
- mdu_done  out  1  final MDU cycle; result valid.
- stall  out  1  freeze PC and IF/ID, bubble ID/EX.
- perf_clr  in  1  synchronous clear of stall_count.
- stall_count  out  PERF_W  cycles with stall asserted.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, cnt = 0, pend_dest = 0, stall_count = 0.
  - mdu_busy = 0, mdu_done = 0.
  - stall reflects only the load-use term.
  - fwd_sel is purely combinational.
- Forwarding (combinational, 0 latency). For each operand i:
  - Select the lowest stage k with stg_regwrite[k], stg_dest[k] != 0 and stg_dest[k] == ex_src[i]; output k+1.
  - If no stage matches, output 0.
  - When several stages match, the nearest stage wins.
  - Register 0 never forwards.
- Load-use term: ex_memread & ex_dest != 0 & (some i with id_src_used[i] & id_src[i] == ex_dest).
- MDU FSM, states IDLE and BUSY:
  - IDLE, mdu_start: latch pend_dest = mdu_dest, cnt = MDU_LAT-1, go to BUSY.
  - BUSY: cnt decrements each cycle. mdu_done = (state == BUSY & cnt == 0).
  - BUSY with cnt == 0 and no start: go to IDLE and clear pend_dest.
  - BUSY with cnt == 0 and mdu_start: back-to-back accept. Reload pend_dest and cnt, stay in BUSY.
  - mdu_start in BUSY with cnt != 0 is ignored. The structural stall below guarantees this cannot happen legally; the bench flags it as an assertion.
  - mdu_busy = (state == BUSY).
- MDU RAW term: BUSY & pend_dest != 0 & some used id_src[i] == pend_dest. The term holds through the done cycle; the result reaches EX/MEM the cycle after done.
- MDU structural term: id_is_mdu & BUSY & !mdu_done.
- stall = load_use | mdu_raw | mdu_struct (combinational from inputs and state).
- stall_count:
  - Increments every cycle with stall = 1.
  - Saturates at all ones.
  - perf_clr has priority over increment; on a simultaneous clear and stall the counter goes to 0.
- Reset mid-operation aborts BUSY immediately; no mdu_done is produced.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef reg_addr_t (REG_AW bits).
  - the FSEL encoding constants (FSEL_RF = 0, FSEL_EXMEM = 1, FSEL_MEMWB = 2).
  - typedef mdu_state_e {IDLE, BUSY}.
- One sub-module, fwd_select: combinational priority encoder for a single operand, instantiated NSRC times via generate.
- Scoreboard, FSM and perf counter stay in the top level.

Test Plan:
- Forwarding priority: stg_dest = {5, 5}, both stg_regwrite = 1, ex_src[0] = 5 -> fwd_sel[0] = 1. With stg_regwrite[0] = 0 -> 2. With dest = 0 on both stages -> 0.
- Load-use: ex_memread = 1, ex_dest = 8, id_src[1] = 8 used -> stall = 1 for that cycle. The same case with id_src_used[1] = 0 -> stall = 0.
- MDU RAW: mdu_start with mdu_dest = 10, MDU_LAT = 4:
  - mdu_busy is high for 4 cycles and mdu_done pulses on the 4th.
  - id_src[0] = 10 -> stall for all 4 cycles, then released.
  - stall_count = 4.
- Back-to-back MDU: second mdu_start on the done cycle -> BUSY continues with no IDLE gap and pend_dest updates. id_is_mdu during cnt != 0 -> stall = 1.
- Reset mid-BUSY: drop rst_n at cnt = 2 -> mdu_busy = 0 immediately, no done pulse, stall_count = 0.
- Counter boundaries:
  - Hold stall for 2^PERF_W + 3 cycles -> stall_count saturates at 0xFFFF.
  - perf_clr together with stall -> 0.
